shdw_fsl_bridge: RTL and testbench
==================================

SHDW_FSL_BRIDGE -- requirements
Module: shdw_fsl_bridge

Interface
REQ-001 SHALL have parameter NUM_CH, default 32: number of shadow channels (1..256).
REQ-002 SHALL have parameter DW, default 32: FSL and shadow data width (>=32).
REQ-003 SHALL have parameter ERR_W, default 12: error-control field width (<=24).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: dump buffer depth (power of 2, >=2).
REQ-005 SHALL have parameter TIMEOUT, default 1024: dump stall limit, in cycles.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 fsl_s_data in DW, fsl_s_ctrl in 1, fsl_s_exists in 1, fsl_s_read out 1: command FSL slave.
REQ-009 fsl_m_data out DW, fsl_m_ctrl out 1, fsl_m_write out 1, fsl_m_full in 1: response FSL master.
REQ-010 err_en out 1, err_ctrl out ERR_W: fault-injection strobe and control word.
REQ-011 sh_rst out 1, c_en out 1: shadow reset pulse, core clock enable.
REQ-012 dump_en out NUM_CH, sh_out in DW, sh_out_vld in NUM_CH, sh_out_done in NUM_CH: per-channel dump handshake.

Function
REQ-013 States: IDLE, DUMP, DRAIN, TRAILER; FSM leaves IDLE only on a dump command.
REQ-014 In IDLE, fsl_s_read = fsl_s_exists (combinational); one command consumed per cycle; fsl_s_read=0 in all other states.
REQ-015 Words with fsl_s_ctrl=1 SHALL be consumed and discarded.
REQ-016 Opcode = fsl_s_data[31:28]; unknown opcodes are consumed with no effect.
REQ-017 0x1: err_ctrl <= data[ERR_W-1:0]; err_en high exactly 1 cycle, the cycle after consumption.
REQ-018 0x2: sh_rst high exactly 1 cycle, the cycle after consumption.
REQ-019 0x3: c_en <= data[0], registered, holds until next 0x3 or reset.
REQ-020 0x4: channel = data[7:0]; if channel >= NUM_CH go to TRAILER with bad-channel flag and count 0; else go to DUMP, clear count and timer.
REQ-021 In DUMP, dump_en[ch]=1 only while FIFO not full; all other dump_en bits 0.
REQ-022 A word is accepted when dump_en[ch] & sh_out_vld[ch]; sh_out pushed to FIFO; count incremented, saturating at 0xFFFF.
REQ-023 vld bits of non-selected channels SHALL be ignored.
REQ-024 sh_out_done[ch] ends DUMP -> DRAIN; a word valid in the same cycle as done is accepted.
REQ-025 FIFO pops to FSL master whenever non-empty and fsl_m_full=0; fsl_m_write high for that cycle, fsl_m_ctrl=0; word order preserved; no word lost or duplicated under backpressure.
REQ-026 DRAIN -> TRAILER when FIFO empty.
REQ-027 TRAILER: when fsl_m_full=0, write fsl_m_ctrl=1, fsl_m_data = {4'hD, timeout flag [27], bad-channel flag [26], 2'b0, ch [23:16], count [15:0]} (upper bits 0 if DW>32); then -> IDLE.
REQ-028 fsl_m_write never asserted while fsl_m_full=1.

Reset
REQ-029 On rst: FSM IDLE; FIFO empty; count, timer, flags 0; fsl_m_write, fsl_m_ctrl, fsl_s_read, err_en, sh_rst, c_en 0; err_ctrl 0; dump_en 0; fsl_m_data 0.
REQ-030 rst mid-dump SHALL abort with no trailer and discard buffered words.

Configuration
REQ-031 Macro SHDW_DUMP_TIMEOUT_EN defined: timer counts DUMP cycles with no accepted word, cleared on each accept; reaching TIMEOUT -> DRAIN with timeout flag set.
REQ-032 Macro undefined: no timer logic; DUMP exits only on done or reset; trailer bit 27 always 0.

Verification
REQ-033 Push 0x1000_0ABC -> err_ctrl=12'hABC, err_en high 1 cycle; push 0x3000_0001 -> c_en=1.
REQ-034 Push 0x4000_0005, channel 5 supplies 3 words then done -> 3 data words ctrl=0 in order, trailer 0xD005_0003 ctrl=1.
REQ-035 Same dump with fsl_m_full toggling every other cycle, FIFO_DEPTH=2 -> dump_en[5] drops when full, identical output stream.
REQ-036 Push 0x4000_00FF with NUM_CH=32 -> immediate trailer 0xD4FF_0000, no dump_en activity.
REQ-037 SHDW_DUMP_TIMEOUT_EN, TIMEOUT=16, channel 2 sends 1 word then stalls -> trailer 0xD802_0001 after 16 idle cycles; without macro FSM remains in DUMP.
REQ-038 Assert rst during DUMP with 2 buffered words -> all outputs at reset values next cycle, no further fsl_m_write.

Source files
------------

// File: rtl/shdw_fsl_bridge.sv
// FSL command bridge for a shadow scan chain: decodes commands, dumps one channel through a FIFO, ends with a trailer (optional stall timer: SHDW_DUMP_TIMEOUT_EN).
// Command consumed in 1 cycle, dump words leave >=1 cycle after capture; dump_en drops when the FIFO fills, FSL writes stall on fsl_m_full.

module shdw_fsl_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module shdw_fsl_bridge #(
  parameter int NUM_CH     = 32,
  parameter int DW         = 32,
  parameter int ERR_W      = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     fsl_s_data,
  input  logic              fsl_s_ctrl,
  input  logic              fsl_s_exists,
  output logic              fsl_s_read,
  output logic [DW-1:0]     fsl_m_data,
  output logic              fsl_m_ctrl,
  output logic              fsl_m_write,
  input  logic              fsl_m_full,
  output logic              err_en,
  output logic [ERR_W-1:0]  err_ctrl,
  output logic              sh_rst,
  output logic              c_en,
  output logic [NUM_CH-1:0] dump_en,
  input  logic [DW-1:0]     sh_out,
  input  logic [NUM_CH-1:0] sh_out_vld,
  input  logic [NUM_CH-1:0] sh_out_done
);
  typedef enum logic [1:0] {S_IDLE, S_DUMP, S_DRAIN, S_TRAILER} state_e;

  state_e            state_q;
  logic [ERR_W-1:0]  err_ctrl_q;
  logic              err_en_q, sh_rst_q, c_en_q;
  logic [7:0]        ch_q;
  logic [15:0]       cnt_q, cnt_d;
  logic              bad_q, tmo_q;

  logic [NUM_CH-1:0] ch_oh;
  logic              cmd_vld, bad_ch, sel_vld, sel_done, accept, tmo_hit;
  logic [3:0]        opcode;
  logic              fifo_full, fifo_empty, fifo_pop, trailer_wr;
  logic [DW-1:0]     fifo_rdata;
  logic              unused_bits;

  assign fsl_s_read = !rst && (state_q == S_IDLE) && fsl_s_exists;
  assign cmd_vld    = fsl_s_read && !fsl_s_ctrl;
  assign opcode     = fsl_s_data[31:28];
  assign bad_ch     = ({1'b0, fsl_s_data[7:0]} >= 9'(NUM_CH));
  assign unused_bits = ^fsl_s_data;

  always_comb begin
    ch_oh = '0;
    for (int i = 0; i < NUM_CH; i++) ch_oh[i] = (ch_q == 8'(i));
  end

  // Only the selected channel's handshake bits are looked at.
  assign dump_en  = (state_q == S_DUMP && !fifo_full) ? ch_oh : '0;
  assign sel_vld  = |(sh_out_vld & ch_oh);
  assign sel_done = |(sh_out_done & ch_oh);
  assign accept   = (state_q == S_DUMP) && !fifo_full && sel_vld;
  assign cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

`ifdef SHDW_DUMP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q;
  assign tmo_hit = !accept && (timer_q == TW'(TIMEOUT - 1));
`else
  // Without the timer a stalled dump waits for done or reset.
  assign tmo_hit = (TIMEOUT < 0);
`endif

  shdw_fsl_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .wdata_i (sh_out),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign fifo_pop    = !rst && !fifo_empty && !fsl_m_full;
  assign trailer_wr  = !rst && (state_q == S_TRAILER) && !fsl_m_full;
  assign fsl_m_write = fifo_pop || trailer_wr;
  assign fsl_m_ctrl  = trailer_wr;

  always_comb begin
    fsl_m_data = '0;
    if (trailer_wr)    fsl_m_data[31:0] = {4'hD, tmo_q, bad_q, 2'b00, ch_q, cnt_q};
    else if (fifo_pop) fsl_m_data = fifo_rdata;
  end

  assign err_en   = err_en_q;
  assign err_ctrl = err_ctrl_q;
  assign sh_rst   = sh_rst_q;
  assign c_en     = c_en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      err_ctrl_q <= '0;
      err_en_q   <= 1'b0;
      sh_rst_q   <= 1'b0;
      c_en_q     <= 1'b0;
      ch_q       <= '0;
      cnt_q      <= '0;
      bad_q      <= 1'b0;
      tmo_q      <= 1'b0;
`ifdef SHDW_DUMP_TIMEOUT_EN
      timer_q    <= '0;
`endif
    end else begin
      err_en_q <= 1'b0;
      sh_rst_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_vld) begin
            case (opcode)
              4'h1: begin
                err_ctrl_q <= fsl_s_data[ERR_W-1:0];
                err_en_q   <= 1'b1;
              end
              4'h2: sh_rst_q <= 1'b1;
              4'h3: c_en_q   <= fsl_s_data[0];
              4'h4: begin
                ch_q    <= fsl_s_data[7:0];
                cnt_q   <= '0;
                tmo_q   <= 1'b0;
                bad_q   <= bad_ch;
                state_q <= bad_ch ? S_TRAILER : S_DUMP;
`ifdef SHDW_DUMP_TIMEOUT_EN
                timer_q <= '0;
`endif
              end
              default: ;
            endcase
          end
        end
        S_DUMP: begin
          if (accept) cnt_q <= cnt_d;
`ifdef SHDW_DUMP_TIMEOUT_EN
          timer_q <= accept ? '0 : timer_q + 1'b1;
`endif
          if (sel_done) begin
            state_q <= S_DRAIN;
          end else if (tmo_hit) begin
            tmo_q   <= 1'b1;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_empty) state_q <= S_TRAILER;
        end
        S_TRAILER: begin
          if (trailer_wr) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shdw_fsl_bridge.sv
// Directed bench for shdw_fsl_bridge: command vector table plus dump, backpressure, bad-channel, stall and reset sequences.
module tb_shdw_fsl_bridge;
  localparam int NCH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fsl_s_data;
  logic        fsl_s_ctrl, fsl_s_exists, fsl_s_read;
  logic [31:0] fsl_m_data;
  logic        fsl_m_ctrl, fsl_m_write, fsl_m_full;
  logic        err_en, sh_rst, c_en;
  logic [11:0] err_ctrl;
  logic [31:0] dump_en, sh_out_vld, sh_out_done;
  logic [31:0] sh_out;

  shdw_fsl_bridge #(.NUM_CH(NCH), .DW(32), .ERR_W(12), .FIFO_DEPTH(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .fsl_s_data(fsl_s_data), .fsl_s_ctrl(fsl_s_ctrl), .fsl_s_exists(fsl_s_exists), .fsl_s_read(fsl_s_read),
    .fsl_m_data(fsl_m_data), .fsl_m_ctrl(fsl_m_ctrl), .fsl_m_write(fsl_m_write), .fsl_m_full(fsl_m_full),
    .err_en(err_en), .err_ctrl(err_ctrl), .sh_rst(sh_rst), .c_en(c_en),
    .dump_en(dump_en), .sh_out(sh_out), .sh_out_vld(sh_out_vld), .sh_out_done(sh_out_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int wr_cnt = 0, trl_cnt = 0, viol = 0, stray = 0, rd_idx = 0;
  logic [32:0] mon_q[$];

  always @(negedge clk) begin
    if (fsl_m_write) begin
      mon_q.push_back({fsl_m_ctrl, fsl_m_data});
      wr_cnt++;
      if (fsl_m_ctrl) trl_cnt++;
      if (fsl_m_full) viol++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [32:0] exp);
    if (rd_idx < mon_q.size()) begin
      chk(name, 64'(mon_q[rd_idx]), 64'(exp));
      rd_idx++;
    end else begin
      checks++;
      errors++;
      $display("FAIL %s actual=none required=%0h", name, exp);
    end
  endtask

  function automatic logic [31:0] word(input int ch, input int i);
    return 32'h5A00_0000 + 32'(i) * 32'h0101_0101 + 32'(ch);
  endfunction

  task automatic send_cmd(input logic [31:0] d);
    fsl_s_data   = d;
    fsl_s_ctrl   = 1'b0;
    fsl_s_exists = 1'b1;
    @(posedge clk); #1;
    fsl_s_exists = 1'b0;
  endtask

  // Plays channel ch: n words, optional done with the last one; other channels hold vld high as noise.
  task automatic run_dump(input int ch, input int n, input bit bp, input bit give_done,
                          input bit exp_trl, input int budget, output int drops);
    int idx, k, t0;
    logic [31:0] oh;
    idx = 0; k = 0; t0 = trl_cnt; drops = 0;
    oh = (ch < NCH) ? (32'h1 << ch) : 32'h0;
    send_cmd(32'h4000_0000 | 32'(ch));
    while (trl_cnt == t0 && k < budget) begin
      if (bp) fsl_m_full = (((k >> 1) & 1) == 0);
      sh_out_vld  = ~oh;
      sh_out_done = '0;
      sh_out      = word(ch, idx);
      if (ch < NCH) begin
        sh_out_vld[ch] = (idx < n);
        if (give_done && idx == n - 1 && dump_en[ch]) sh_out_done[ch] = 1'b1;
      end
      @(negedge clk);
      if ((dump_en & ~oh) != '0) stray++;
      if (ch < NCH && idx < n) begin
        if (dump_en[ch]) idx++;
        else drops++;
      end
      @(posedge clk); #1;
      k++;
    end
    sh_out_vld  = '0;
    sh_out_done = '0;
    fsl_m_full  = 1'b0;
    chk("trailer_seen", 64'(trl_cnt != t0), 64'(exp_trl));
  endtask

  typedef struct {
    logic [31:0] data;
    logic        ctrl;
    logic [11:0] e_ctrl;
    logic        e_cen;
    logic        e_err;
    logic        e_shr;
  } vec_t;

  vec_t vt[10];

  initial begin
    int drops, k, t0, w0;
    vt[0] = '{32'h1000_0ABC, 1'b0, 12'hABC, 1'b0, 1'b1, 1'b0};
    vt[1] = '{32'h3000_0001, 1'b0, 12'hABC, 1'b1, 1'b0, 1'b0};
    vt[2] = '{32'h1000_0123, 1'b1, 12'hABC, 1'b1, 1'b0, 1'b0};
    vt[3] = '{32'h2000_0000, 1'b0, 12'hABC, 1'b1, 1'b0, 1'b1};
    vt[4] = '{32'h7000_0FFF, 1'b0, 12'hABC, 1'b1, 1'b0, 1'b0};
    vt[5] = '{32'h1FFF_F555, 1'b0, 12'h555, 1'b1, 1'b1, 1'b0};
    vt[6] = '{32'h3FFF_FFFE, 1'b0, 12'h555, 1'b0, 1'b0, 1'b0};
    vt[7] = '{32'hF000_0001, 1'b0, 12'h555, 1'b0, 1'b0, 1'b0};
    vt[8] = '{32'h4000_0001, 1'b1, 12'h555, 1'b0, 1'b0, 1'b0};
    vt[9] = '{32'h3000_0003, 1'b0, 12'h555, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; fsl_s_data = '0; fsl_s_ctrl = 1'b0; fsl_s_exists = 1'b0;
    fsl_m_full = 1'b0; sh_out = '0; sh_out_vld = '0; sh_out_done = '0;
    repeat (2) @(posedge clk);
    #1 fsl_s_exists = 1'b1; fsl_s_data = 32'h1000_0ABC;
    @(negedge clk);
    chk("rst_s_read", fsl_s_read, 0);
    chk("rst_err_en", err_en, 0);
    chk("rst_err_ctrl", err_ctrl, 0);
    chk("rst_c_en", c_en, 0);
    chk("rst_sh_rst", sh_rst, 0);
    chk("rst_dump_en", dump_en, 0);
    chk("rst_m_write", fsl_m_write, 0);
    chk("rst_m_ctrl", fsl_m_ctrl, 0);
    chk("rst_m_data", fsl_m_data, 0);
    @(posedge clk); #1;
    fsl_s_exists = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ignored", err_ctrl, 0);
    @(posedge clk); #1;

    foreach (vt[i]) begin
      fsl_s_data = vt[i].data; fsl_s_ctrl = vt[i].ctrl; fsl_s_exists = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_s_read", i), fsl_s_read, 1);
      @(posedge clk); #1;
      fsl_s_exists = 1'b0; fsl_s_ctrl = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_err_ctrl", i), err_ctrl, vt[i].e_ctrl);
      chk($sformatf("vec%0d_c_en", i), c_en, vt[i].e_cen);
      chk($sformatf("vec%0d_err_en", i), err_en, vt[i].e_err);
      chk($sformatf("vec%0d_sh_rst", i), sh_rst, vt[i].e_shr);
      chk($sformatf("vec%0d_dump_en", i), dump_en, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_pulse_end", i), {err_en, sh_rst}, 0);
      @(posedge clk); #1;
    end
    chk("ctrl_words_no_output", wr_cnt, 0);

    // Back-to-back commands: one per cycle.
    fsl_s_data = 32'h1000_0111; fsl_s_exists = 1'b1;
    @(posedge clk); #1 fsl_s_data = 32'h1000_0222;
    @(negedge clk);
    chk("b2b_read", fsl_s_read, 1);
    chk("b2b_first", {err_en, err_ctrl}, {1'b1, 12'h111});
    @(posedge clk); #1 fsl_s_exists = 1'b0;
    @(negedge clk);
    chk("b2b_second", {err_en, err_ctrl}, {1'b1, 12'h222});
    @(negedge clk);
    chk("b2b_err_en_low", err_en, 0);
    @(posedge clk); #1;

    run_dump(5, 3, 1'b0, 1'b1, 1'b1, 100, drops);
    for (int i = 0; i < 3; i++) chk_out($sformatf("dump_w%0d", i), {1'b0, word(5, i)});
    chk_out("dump_trailer", 33'h1_D005_0003);

    run_dump(5, 3, 1'b1, 1'b1, 1'b1, 200, drops);
    chk("bp_dump_en_drop", 64'(drops > 0), 1);
    for (int i = 0; i < 3; i++) chk_out($sformatf("bp_w%0d", i), {1'b0, word(5, i)});
    chk_out("bp_trailer", 33'h1_D005_0003);

    run_dump(255, 0, 1'b0, 1'b0, 1'b1, 30, drops);
    chk_out("bad_ff_trailer", 33'h1_D4FF_0000);
    run_dump(32, 0, 1'b0, 1'b0, 1'b1, 30, drops);
    chk_out("bad_32_trailer", 33'h1_D420_0000);

    run_dump(31, 1, 1'b0, 1'b1, 1'b1, 50, drops);
    chk_out("ch31_w0", {1'b0, word(31, 0)});
    chk_out("ch31_trailer", 33'h1_D01F_0001);

`ifdef SHDW_DUMP_TIMEOUT_EN
    run_dump(2, 1, 1'b0, 1'b0, 1'b1, 100, drops);
    chk_out("tmo_w0", {1'b0, word(2, 0)});
    chk_out("tmo_trailer", 33'h1_D802_0001);
`else
    run_dump(2, 1, 1'b0, 1'b0, 1'b0, 60, drops);
    chk("stall_still_dump", dump_en[2], 1);
    chk_out("stall_w0", {1'b0, word(2, 0)});
    t0 = trl_cnt;
    sh_out_done[2] = 1'b1;
    @(posedge clk); #1 sh_out_done = '0;
    k = 0;
    while (trl_cnt == t0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk_out("stall_trailer", 33'h1_D002_0001);
`endif

    // Reset while two words sit in the FIFO behind a full master.
    fsl_m_full = 1'b1;
    send_cmd(32'h4000_0005);
    k = 0; w0 = 0;
    while (w0 < 2 && k < 20) begin
      sh_out_vld = 32'h20; sh_out = word(5, w0);
      @(negedge clk);
      if (dump_en[5]) w0++;
      @(posedge clk); #1;
      k++;
    end
    sh_out_vld = '0;
    @(negedge clk);
    chk("full_fifo_dump_en", dump_en, 0);
    w0 = wr_cnt;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; fsl_m_full = 1'b0;
    @(negedge clk);
    chk("mid_rst_dump_en", dump_en, 0);
    chk("mid_rst_m_write", fsl_m_write, 0);
    chk("mid_rst_m_data", fsl_m_data, 0);
    chk("mid_rst_c_en", c_en, 0);
    chk("mid_rst_err_ctrl", err_ctrl, 0);
    repeat (20) @(negedge clk);
    chk("mid_rst_no_write", wr_cnt - w0, 0);
    @(posedge clk); #1;
    send_cmd(32'h3000_0001);
    @(negedge clk);
    chk("post_rst_cmd", c_en, 1);

    chk("write_while_full", viol, 0);
    chk("stray_dump_en", stray, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
